// File: rtl/mpmc11_mig_app_responder.sv
// Stand-in for the DDR IP user interface: calibration delay, write-data FIFO,
// fixed-latency read return, back-pressure and refresh handshake over a word array.
module mpmc11_mig_app_responder #(
    parameter int DW           = 256,
    parameter int AW           = 29,
    parameter int DEPTH        = 4096,
    parameter int ADDR_SHIFT   = 5,
    parameter int CAL_CYCLES   = 64,
    parameter int RD_LAT       = 8,
    parameter int RQ_DEPTH     = 8,
    parameter int STALL_PERIOD = 0,
    parameter int REF_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              calib_complete,
    input  logic              app_en,
    input  logic [2:0]        app_cmd,
    input  logic [AW-1:0]     app_addr,
    output logic              app_rdy,
    input  logic              app_wdf_wren,
    input  logic [DW-1:0]     app_wdf_data,
    input  logic [DW/8-1:0]   app_wdf_mask,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [DW-1:0]     app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end,
    input  logic              app_ref_req,
    output logic              app_ref_ack
);
    localparam int MW        = DW / 8;
    localparam int IW        = $clog2(DEPTH);
    localparam int QW        = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW        = QW + 1;
    localparam int STALL_TOP = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;

    typedef enum logic [1:0] {CALIB, RUN, REFRESH} state_t;

    state_t        state_q;
    logic [15:0]   cal_cnt_q, ref_cnt_q;
    logic          ref_pend_q, calib_q, ref_ack_q;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wdf_data_mem [4];
    logic [MW-1:0] wdf_mask_mem [4];
    logic [IW-1:0] rq_idx_mem [RQ_DEPTH];
    logic [4:0]    rq_due_mem [RQ_DEPTH];

    logic [1:0]    wdf_wr_ptr_q, wdf_wr_ptr_d, wdf_rd_ptr_q, wdf_rd_ptr_d;
    logic [2:0]    wdf_count_q, wdf_count_d;
    logic          pend_wr_v_q, pend_wr_v_d;
    logic [IW-1:0] pend_wr_idx_q, pend_wr_idx_d;
    logic [QW-1:0] rq_wr_ptr_q, rq_wr_ptr_d, rq_rd_ptr_q, rq_rd_ptr_d;
    logic [CW-1:0] rq_count_q, rq_count_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          stall, rq_full, beat, acc, wr_acc, rd_acc, rq_retire;
    logic          wdf_push, wdf_pop, commit_en;
    logic [IW-1:0] cmd_idx, commit_idx;
    logic [DW-1:0] commit_data;
    logic [MW-1:0] commit_mask;
    logic          unused_inputs;

    assign unused_inputs = ^{app_wdf_end, app_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CALIB;
            cal_cnt_q  <= 16'(CAL_CYCLES - 1);
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            calib_q    <= 1'b0;
            ref_ack_q  <= 1'b0;
        end else begin
            ref_ack_q <= 1'b0;
            case (state_q)
                CALIB: begin
                    if (app_ref_req) ref_pend_q <= 1'b1;
                    if (cal_cnt_q == 16'd0) begin
                        state_q <= RUN;
                        calib_q <= 1'b1;
                    end else begin
                        cal_cnt_q <= cal_cnt_q - 16'd1;
                    end
                end
                RUN: begin
                    if (app_ref_req || ref_pend_q) begin
                        state_q    <= REFRESH;
                        ref_pend_q <= 1'b0;
                        ref_cnt_q  <= 16'(REF_CYCLES - 1);
                    end
                end
                REFRESH: begin
                    // requests arriving here fold into the refresh already running
                    if (ref_cnt_q == 16'd0) begin
                        state_q   <= RUN;
                        ref_ack_q <= 1'b1;
                    end else begin
                        ref_cnt_q <= ref_cnt_q - 16'd1;
                    end
                end
                default: state_q <= CALIB;
            endcase
        end
    end

    assign stall       = (STALL_PERIOD != 0) && (stall_cnt_q == 16'd0);
    assign rq_full     = (rq_count_q == CW'(RQ_DEPTH));
    assign app_rdy     = (state_q == RUN) && !rq_full && !pend_wr_v_q && !stall;
    assign app_wdf_rdy = (state_q != CALIB) && (wdf_count_q < 3'd4);
    assign beat        = app_wdf_wren && app_wdf_rdy;
    assign acc         = app_en && app_rdy;
    assign wr_acc      = acc && (app_cmd == 3'b000);
    assign rd_acc      = acc && (app_cmd == 3'b001);
    assign cmd_idx     = app_addr[ADDR_SHIFT +: IW];
    assign rq_retire   = (rq_count_q != '0) && (rq_due_mem[rq_rd_ptr_q] == 5'd0);

    always_comb begin
        wdf_push      = 1'b0;
        wdf_pop       = 1'b0;
        commit_en     = 1'b0;
        commit_idx    = pend_wr_idx_q;
        commit_data   = app_wdf_data;
        commit_mask   = app_wdf_mask;
        pend_wr_v_d   = pend_wr_v_q;
        pend_wr_idx_d = pend_wr_idx_q;
        if (pend_wr_v_q) begin
            if (beat) begin
                commit_en   = 1'b1;
                pend_wr_v_d = 1'b0;
            end
        end else if (wr_acc) begin
            commit_idx = cmd_idx;
            if (wdf_count_q != 3'd0) begin
                wdf_pop     = 1'b1;
                wdf_push    = beat;
                commit_en   = 1'b1;
                commit_data = wdf_data_mem[wdf_rd_ptr_q];
                commit_mask = wdf_mask_mem[wdf_rd_ptr_q];
            end else if (beat) begin
                commit_en = 1'b1;
            end else begin
                pend_wr_v_d   = 1'b1;
                pend_wr_idx_d = cmd_idx;
            end
        end else begin
            wdf_push = beat;
        end
        wdf_wr_ptr_d = wdf_wr_ptr_q + 2'(wdf_push);
        wdf_rd_ptr_d = wdf_rd_ptr_q + 2'(wdf_pop);
        wdf_count_d  = wdf_count_q + 3'(wdf_push) - 3'(wdf_pop);

        rq_wr_ptr_d = rq_wr_ptr_q + QW'(rd_acc);
        rq_rd_ptr_d = rq_rd_ptr_q + QW'(rq_retire);
        rq_count_d  = rq_count_q + CW'(rd_acc) - CW'(rq_retire);
        rd_valid_d  = rq_retire;
        rd_data_d   = rq_retire ? mem[rq_idx_mem[rq_rd_ptr_q]] : rd_data_q;

        if (STALL_PERIOD == 0)          stall_cnt_d = 16'd0;
        else if (stall_cnt_q == 16'd0)  stall_cnt_d = 16'(STALL_TOP);
        else                            stall_cnt_d = stall_cnt_q - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdf_wr_ptr_q  <= '0;
            wdf_rd_ptr_q  <= '0;
            wdf_count_q   <= '0;
            pend_wr_v_q   <= 1'b0;
            pend_wr_idx_q <= '0;
            rq_wr_ptr_q   <= '0;
            rq_rd_ptr_q   <= '0;
            rq_count_q    <= '0;
            stall_cnt_q   <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            wdf_wr_ptr_q  <= wdf_wr_ptr_d;
            wdf_rd_ptr_q  <= wdf_rd_ptr_d;
            wdf_count_q   <= wdf_count_d;
            pend_wr_v_q   <= pend_wr_v_d;
            pend_wr_idx_q <= pend_wr_idx_d;
            rq_wr_ptr_q   <= rq_wr_ptr_d;
            rq_rd_ptr_q   <= rq_rd_ptr_d;
            rq_count_q    <= rq_count_d;
            stall_cnt_q   <= stall_cnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Storage without reset; each read slot counts down to its return cycle.
    always_ff @(posedge clk) begin
        if (wdf_push) begin
            wdf_data_mem[wdf_wr_ptr_q] <= app_wdf_data;
            wdf_mask_mem[wdf_wr_ptr_q] <= app_wdf_mask;
        end
        for (int i = 0; i < RQ_DEPTH; i++) begin
            if (rq_due_mem[i] != 5'd0) rq_due_mem[i] <= rq_due_mem[i] - 5'd1;
        end
        if (rd_acc) begin
            rq_idx_mem[rq_wr_ptr_q] <= cmd_idx;
            rq_due_mem[rq_wr_ptr_q] <= 5'(RD_LAT - 1);
        end
        if (commit_en && !rst) begin
            for (int b = 0; b < MW; b++) begin
                if (!commit_mask[b]) mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
            end
        end
    end

    assign calib_complete    = calib_q;
    assign app_ref_ack       = ref_ack_q;
    assign app_rd_data_valid = rd_valid_q;
    assign app_rd_data_end   = rd_valid_q;
    assign app_rd_data       = rd_data_q;
endmodule

// File: tb/tb_mpmc11_mig_app_responder.sv
// Directed bench for mpmc11_mig_app_responder with a queue-based reference model
// checked against the DUT outputs every cycle.
module tb_mpmc11_mig_app_responder;
    localparam int DW   = 256;
    localparam int AW   = 29;
    localparam int MW   = 32;
    localparam int CAL  = 64;
    localparam int RDL  = 8;
    localparam int RQD  = 8;
    localparam int REFC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          app_en = 1'b0;
    logic [2:0]    app_cmd = 3'b000;
    logic [AW-1:0] app_addr = '0;
    logic          app_wdf_wren = 1'b0;
    logic [DW-1:0] app_wdf_data = '0;
    logic [MW-1:0] app_wdf_mask = '0;
    logic          app_wdf_end = 1'b0;
    logic          app_ref_req = 1'b0;
    logic          calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_ref_ack;
    logic [DW-1:0] app_rd_data;

    int vectors = 0;
    int miscompares = 0;

    mpmc11_mig_app_responder #(
        .DW(DW), .AW(AW), .DEPTH(4096), .ADDR_SHIFT(5), .CAL_CYCLES(CAL), .RD_LAT(RDL),
        .RQ_DEPTH(RQD), .STALL_PERIOD(0), .REF_CYCLES(REFC)
    ) dut (
        .clk(clk), .rst(rst), .calib_complete(calib_complete),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .app_ref_req(app_ref_req), .app_ref_ack(app_ref_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: t is the cycle index since the last reset edge.
    typedef struct {int idx; int due;} rd_t;
    rd_t               rq_m[$];
    int                cmdq_m[$];
    logic [DW-1:0]     dq_m[$];
    logic [MW-1:0]     mq_m[$];
    logic [DW-1:0]     mem_m[int];
    int                t = 0;
    int                ref_start = -1;
    bit                ref_latch = 0;
    bit                model_ready = 0;
    bit                exp_valid = 0;
    bit                exp_ack = 0;
    logic [DW-1:0]     exp_data = '0;

    function automatic int widx(input logic [AW-1:0] a);
        return (int'(a) >> 5) % 4096;
    endfunction
    function automatic bit m_in_ref();
        return ref_start >= 0 && t >= ref_start && t < ref_start + REFC;
    endfunction
    function automatic bit m_run();
        return t >= CAL && !m_in_ref();
    endfunction
    function automatic bit m_rdy();
        return m_run() && rq_m.size() < RQD && cmdq_m.size() == 0;
    endfunction
    function automatic bit m_wdf_rdy();
        return t >= CAL && dq_m.size() < 4;
    endfunction

    always @(posedge clk) begin : model
        bit cur_rdy, cur_wdf, cur_run, cur_cal;
        model_ready = 1;
        if (rst) begin
            t = 0; ref_start = -1; ref_latch = 0;
            rq_m.delete(); cmdq_m.delete(); dq_m.delete(); mq_m.delete();
            exp_valid = 0; exp_ack = 0; exp_data = '0;
        end else begin
            cur_rdy = m_rdy(); cur_wdf = m_wdf_rdy(); cur_run = m_run(); cur_cal = (t < CAL);
            exp_valid = 0;
            exp_ack = (ref_start >= 0 && t + 1 == ref_start + REFC);
            if (rq_m.size() > 0 && rq_m[0].due == t + 1) begin
                exp_valid = 1;
                exp_data = mem_m.exists(rq_m[0].idx) ? mem_m[rq_m[0].idx] : '0;
                void'(rq_m.pop_front());
            end
            if (app_en && cur_rdy && app_cmd == 3'b001) rq_m.push_back('{widx(app_addr), t + 1 + RDL});
            if (app_en && cur_rdy && app_cmd == 3'b000) cmdq_m.push_back(widx(app_addr));
            if (app_wdf_wren && cur_wdf) begin
                dq_m.push_back(app_wdf_data);
                mq_m.push_back(app_wdf_mask);
            end
            while (cmdq_m.size() > 0 && dq_m.size() > 0) begin
                int ci;
                logic [DW-1:0] w, d;
                logic [MW-1:0] m;
                ci = cmdq_m.pop_front(); d = dq_m.pop_front(); m = mq_m.pop_front();
                w = mem_m.exists(ci) ? mem_m[ci] : '0;
                for (int b = 0; b < MW; b++) if (!m[b]) w[8*b +: 8] = d[8*b +: 8];
                mem_m[ci] = w;
            end
            if (cur_cal && app_ref_req) ref_latch = 1;
            else if (cur_run && (app_ref_req || ref_latch)) begin
                ref_start = t + 1;
                ref_latch = 0;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("calib_complete", calib_complete, (t >= CAL));
            check("app_rdy", app_rdy, m_rdy());
            check("app_wdf_rdy", app_wdf_rdy, m_wdf_rdy());
            check("rd_data_valid", app_rd_data_valid, exp_valid);
            check("rd_data_end", app_rd_data_end, exp_valid);
            check("ref_ack", app_ref_ack, exp_ack);
            if (exp_valid) check("rd_data", app_rd_data, exp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit need_wdf, output int waited);
        waited = 0;
        while (!(app_rdy === 1'b1 && (!need_wdf || app_wdf_rdy === 1'b1)) && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) check("rdy_timeout", 256'd0, 256'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        int w;
        app_en = 1; app_cmd = 3'b000; app_addr = a;
        app_wdf_wren = 1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1;
        wait_rdy(1, w);
        tick();
        app_en = 0; app_wdf_wren = 0; app_wdf_end = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int w;
        app_en = 1; app_cmd = 3'b001; app_addr = a;
        wait_rdy(0, w);
        tick();
        app_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] lit;
        int w, rdy0, ack_n, val_n;

        repeat (3) tick();
        rst = 0;
        check("reset_rd_data", app_rd_data, '0);
        check("reset_valid", app_rd_data_valid, 1'b0);
        check("reset_ack", app_ref_ack, 1'b0);
        check("reset_wdf_rdy", app_wdf_rdy, 1'b0);
        for (int k = 0; k < CAL; k++) begin
            check("calib_low", calib_complete, 1'b0);
            check("calib_rdy_low", app_rdy, 1'b0);
            tick();
        end
        check("calib_high", calib_complete, 1'b1);

        // plain write with data in the same cycle, then read latency
        do_write(29'h40, {32{8'hA5}}, '0);
        do_read(29'h40);
        repeat (RDL - 1) tick();
        check("lat_early", app_rd_data_valid, 1'b0);
        tick();
        check("lat_valid", app_rd_data_valid, 1'b1);
        lit = {32{8'hA5}};
        check("lat_data", app_rd_data, lit);

        // byte-masked write
        do_write(29'h80, {32{8'h11}}, '0);
        do_write(29'h80, {32{8'h22}}, 32'hFFFF_FFFE);
        do_read(29'h80);
        repeat (RDL) tick();
        lit = {{31{8'h11}}, 8'h22};
        check("mask_data", app_rd_data, lit);

        // command ahead of its data
        app_en = 1; app_cmd = 3'b000; app_addr = 29'hC0;
        wait_rdy(0, w);
        tick();
        app_en = 0;
        for (int k = 0; k < 3; k++) begin
            check("pend_rdy_low", app_rdy, 1'b0);
            if (k < 2) tick();
        end
        check("pend_wdf_rdy", app_wdf_rdy, 1'b1);
        app_wdf_wren = 1; app_wdf_data = {32{8'h5C}}; app_wdf_mask = '0;
        tick();
        app_wdf_wren = 0;
        check("pend_released", app_rdy, 1'b1);
        do_read(29'hC0);
        repeat (RDL) tick();
        lit = {32{8'h5C}};
        check("pend_data", app_rd_data, lit);

        // nine back-to-back reads against an eight-deep queue
        for (int i = 0; i < 9; i++) do_write(29'h1000 + 29'(i * 32), {32{8'(8'h30 + i)}}, '0);
        app_en = 1; app_cmd = 3'b001;
        for (int i = 0; i < 9; i++) begin
            app_addr = 29'h1000 + 29'(i * 32);
            wait_rdy(0, w);
            if (i == 8) check("rq_wait", 32'(w), 32'd1);
            tick();
            if (i == 7) check("rq_full_rdy", app_rdy, 1'b0);
        end
        app_en = 0;
        repeat (RDL + 4) tick();

        // refresh with two reads outstanding and a second request absorbed
        do_read(29'h40);
        do_read(29'h80);
        app_ref_req = 1;
        tick();
        app_ref_req = 0;
        rdy0 = 0; ack_n = 0; val_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!app_rdy) rdy0++;
            if (app_ref_ack) ack_n++;
            if (app_rd_data_valid) val_n++;
            app_ref_req = (k == 5);
            tick();
        end
        app_ref_req = 0;
        check("ref_rdy_low_cycles", 32'(rdy0), 32'd16);
        check("ref_ack_count", 32'(ack_n), 32'd1);
        check("ref_valid_count", 32'(val_n), 32'd2);

        // reset in the middle of a refresh with reads in flight
        do_read(29'h40);
        do_read(29'h80);
        app_ref_req = 1;
        tick();
        app_ref_req = 0;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        ack_n = 0; val_n = 0;
        for (int k = 0; k < 100; k++) begin
            if (app_ref_ack) ack_n++;
            if (app_rd_data_valid) val_n++;
            app_ref_req = (k == 10);
            tick();
        end
        app_ref_req = 0;
        check("post_rst_valid", 32'(val_n), 32'd0);
        check("post_rst_latched_ack", 32'(ack_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
